gpiodpi_change_capture: RTL and testbench
=========================================

GPIODPI_CHANGE_CAPTURE -- requirements
Module: gpiodpi_change_capture

Interface
REQ-001 Parameter N_GPIO, default 32: width of the monitored GPIO vectors.
REQ-002 Parameter DEPTH, default 8: event FIFO depth; SHALL be a power of two and at least 2.
REQ-003 Parameter TS_W, default 32: timestamp counter width.
REQ-004 clk_i  input  1  single clock for all state.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 gpio_d2p_i  input  N_GPIO  device-to-pad output values.
REQ-007 gpio_en_d2p_i  input  N_GPIO  device-to-pad output enables.
REQ-008 evt_valid_o  output  1  FIFO head event is valid.
REQ-009 evt_ready_i  input  1  consumer accepts the head event.
REQ-010 evt_d2p_o  output  N_GPIO  head event value snapshot.
REQ-011 evt_en_o  output  N_GPIO  head event enable snapshot.
REQ-012 evt_ts_o  output  TS_W  head event timestamp.
REQ-013 overflow_o  output  1  sticky flag: an event was dropped.
REQ-014 drop_cnt_o  output  16  saturating count of dropped events.

Function
REQ-015 A free-running counter ts SHALL increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-016 Registers prev_d2p and prev_en SHALL load gpio_d2p_i and gpio_en_d2p_i every cycle.
REQ-017 A change SHALL be detected at a posedge when (gpio_d2p_i != prev_d2p) or (gpio_en_d2p_i != prev_en); each detected change is one event.
REQ-018 On a change, the block SHALL push {gpio_d2p_i, gpio_en_d2p_i, ts} at that same posedge, where ts is the pre-increment value.
REQ-019 evt_valid_o SHALL equal FIFO not-empty; evt_* outputs SHALL be driven from the FIFO head with no combinational path from the gpio inputs.
REQ-020 Latency: for a change sampled at posedge k with an empty FIFO, evt_valid_o SHALL be high immediately after posedge k.
REQ-021 Pop SHALL occur at a posedge where evt_valid_o and evt_ready_i are both high; evt_ready_i SHALL be ignored while the FIFO is empty.
REQ-022 Once evt_valid_o is asserted, the evt_* outputs SHALL stay stable until popped.
REQ-023 Push into a full FIFO without a simultaneous pop SHALL drop the event, set overflow_o, and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-024 Push and pop at the same posedge on a full FIFO SHALL both succeed; no drop is counted.
REQ-025 Push and pop at the same posedge on a one-entry FIFO SHALL leave exactly the new event at the head.
REQ-026 Events SHALL be delivered in push order, with no reordering or merging.

Reset
REQ-027 While rst_i is high: FIFO empty, evt_valid_o=0, evt_d2p_o/evt_en_o/evt_ts_o=0, ts=0, prev_d2p/prev_en=0, overflow_o=0, drop_cnt_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued events immediately, asynchronously to clk_i.
REQ-029 On the first posedge after reset release, any nonzero input SHALL produce an event with ts=0.

Configuration
REQ-030 Macro GPIODPI_CAPTURE_MASK_EN, when defined, SHALL add input gpio_mask_i [N_GPIO]; bits set to 1 SHALL be excluded from change detection but still captured in snapshots.
REQ-031 Without GPIODPI_CAPTURE_MASK_EN, the port SHALL be absent and all bits SHALL be monitored.

Structure
REQ-032 Package gpiodpi_capture_pkg SHALL hold the event struct typedef (d2p, en, ts), default parameter constants, and the drop counter width of 16.
REQ-033 Storage SHALL be a sub-module gpiodpi_capture_fifo: synchronous write/read, full/empty flags, pointers of log2(DEPTH)+1 bits.

Verification
REQ-034 Reset release with d2p=32'h0000_0001, en=32'h1 held -> exactly one event {1,1,ts=0}; no further events.
REQ-035 d2p toggles 0->5->5->A on consecutive cycles starting at ts=100, evt_ready_i=1 -> two events, with ts 100 and 102.
REQ-036 evt_ready_i=0, 10 distinct changes, DEPTH=8 -> 8 events held in order, overflow_o=1, drop_cnt_o=2; the first 8 are delivered intact after ready is raised.
REQ-037 FIFO full, change while ready=1 -> no drop, drop_cnt_o unchanged, occupancy stays 8.
REQ-038 TS_W=4, change at ts=15 and next at ts=0 -> timestamps 15 then 0.
REQ-039 rst_i pulsed mid-stream with 5 events queued -> evt_valid_o=0 immediately, counters are 0, and no stale events appear after release.

Source files
------------

// File: rtl/gpiodpi_capture_pkg.sv
// Shared types and constants for the GPIO change-capture block.
// Optional feature macro: GPIODPI_CAPTURE_MASK_EN (adds gpio_mask_i to the top).
package gpiodpi_capture_pkg;

  localparam int N_GPIO_DEF = 32;
  localparam int DEPTH_DEF  = 8;
  localparam int TS_W_DEF   = 32;
  localparam int DROP_CNT_W = 16;

  // Event record at the default configuration; the top builds the same
  // layout with its own parameter values.
  typedef struct packed {
    logic [N_GPIO_DEF-1:0] d2p;
    logic [N_GPIO_DEF-1:0] en;
    logic [TS_W_DEF-1:0]   ts;
  } gpio_evt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gpiodpi_capture_fifo.sv
// Event storage: synchronous write and pop, head visible combinationally
// from the storage array. Pointers carry one extra wrap bit to tell full
// from empty. Push into a full FIFO succeeds only when a pop happens in
// the same cycle (the freed slot is the one being written).
module gpiodpi_capture_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation for accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/gpiodpi_change_capture.sv
// Captures every change of the GPIO output value/enable vectors as a
// timestamped event and queues it for a ready/valid consumer.
// Optional feature macro: GPIODPI_CAPTURE_MASK_EN adds gpio_mask_i; masked
// bits do not trigger events but are still recorded in snapshots.
module gpiodpi_change_capture
  import gpiodpi_capture_pkg::*;
#(
  parameter int N_GPIO = N_GPIO_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_GPIO-1:0]     gpio_d2p_i,
  input  logic [N_GPIO-1:0]     gpio_en_d2p_i,
`ifdef GPIODPI_CAPTURE_MASK_EN
  input  logic [N_GPIO-1:0]     gpio_mask_i,
`endif
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [N_GPIO-1:0]     evt_d2p_o,
  output logic [N_GPIO-1:0]     evt_en_o,
  output logic [TS_W-1:0]       evt_ts_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  typedef struct packed {
    logic [N_GPIO-1:0] d2p;
    logic [N_GPIO-1:0] en;
    logic [TS_W-1:0]   ts;
  } evt_t;

  logic [TS_W-1:0]       ts_q, ts_d;
  logic [N_GPIO-1:0]     prev_d2p_q, prev_en_q;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [N_GPIO-1:0]     diff;
  logic                  change;
  logic                  fifo_full, fifo_empty;
  logic                  pop;
  logic                  drop;
  evt_t                  wr_evt;
  evt_t                  head_evt;

  assign diff = (gpio_d2p_i ^ prev_d2p_q) | (gpio_en_d2p_i ^ prev_en_q);
`ifdef GPIODPI_CAPTURE_MASK_EN
  assign change = |(diff & ~gpio_mask_i);
`else
  assign change = |diff;
`endif

  // Timestamp is the counter value before this edge's increment.
  assign wr_evt = '{d2p: gpio_d2p_i, en: gpio_en_d2p_i, ts: ts_q};
  assign pop    = evt_ready_i & ~fifo_empty;
  // A full FIFO only loses the event if nothing leaves in the same cycle.
  assign drop   = change & fifo_full & ~pop;

  gpiodpi_capture_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (change),
    .wdata_i (wr_evt),
    .pop_i   (pop),
    .rdata_o (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs come only from registered FIFO state, zeroed while empty.
  assign evt_valid_o = ~fifo_empty;
  assign evt_d2p_o   = fifo_empty ? '0 : head_evt.d2p;
  assign evt_en_o    = fifo_empty ? '0 : head_evt.en;
  assign evt_ts_o    = fifo_empty ? '0 : head_evt.ts;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

  // Next-state for timestamp and drop bookkeeping.
  always_comb begin
    ts_d       = ts_q + 1'b1;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Free-running timestamp, previous-input snapshot and drop state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      prev_d2p_q <= '0;
      prev_en_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_d2p_q <= gpio_d2p_i;
      prev_en_q  <= gpio_en_d2p_i;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_gpiodpi_change_capture.sv
// Directed bench for gpiodpi_change_capture: a default-size instance and a
// second instance with a 4-bit timestamp for wrap behaviour.
module tb_gpiodpi_change_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d2p = '0;
  logic [31:0] en  = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] evt_d2p, evt_en, evt_ts;
  logic        ovf;
  logic [15:0] drops;

  logic [31:0] d2p4 = '0;
  logic [31:0] en4  = '0;
  logic        ready4 = 1'b0;
  logic        valid4;
  logic [31:0] evt_d2p4, evt_en4;
  logic [3:0]  evt_ts4;
  logic        ovf4;
  logic [15:0] drops4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpiodpi_change_capture dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .gpio_d2p_i    (d2p),
    .gpio_en_d2p_i (en),
`ifdef GPIODPI_CAPTURE_MASK_EN
    .gpio_mask_i   (32'h0),
`endif
    .evt_valid_o   (valid),
    .evt_ready_i   (ready),
    .evt_d2p_o     (evt_d2p),
    .evt_en_o      (evt_en),
    .evt_ts_o      (evt_ts),
    .overflow_o    (ovf),
    .drop_cnt_o    (drops)
  );

  gpiodpi_change_capture #(.TS_W(4)) dut4 (
    .clk_i         (clk),
    .rst_i         (rst),
    .gpio_d2p_i    (d2p4),
    .gpio_en_d2p_i (en4),
`ifdef GPIODPI_CAPTURE_MASK_EN
    .gpio_mask_i   (32'h0),
`endif
    .evt_valid_o   (valid4),
    .evt_ready_i   (ready4),
    .evt_d2p_o     (evt_d2p4),
    .evt_en_o      (evt_en4),
    .evt_ts_o      (evt_ts4),
    .overflow_o    (ovf4),
    .drop_cnt_o    (drops4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held across two edges, released between edges.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_d2p", evt_d2p, 0);
    chk("rst_en", evt_en, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drops", drops, 0);

    // Nonzero inputs across reset release: one event with ts 0
    d2p = 32'h1; en = 32'h1;
    do_reset();
    tick();
    chk("first_valid", valid, 1);
    chk("first_d2p", evt_d2p, 1);
    chk("first_en", evt_en, 1);
    chk("first_ts", evt_ts, 0);
    repeat (3) tick();
    chk("first_hold_valid", valid, 1);
    chk("first_hold_ts", evt_ts, 0);
    ready = 1'b1;
    tick();
    chk("first_popped", valid, 0);
    repeat (3) tick();
    chk("first_no_more", valid, 0);

    // 0 -> 5 -> 5 -> A starting at ts 100 with ready high
    d2p = '0; en = '0;
    do_reset();
    repeat (100) tick();
    d2p = 32'h5;
    tick();
    chk("tog_valid0", valid, 1);
    chk("tog_d2p0", evt_d2p, 5);
    chk("tog_ts0", evt_ts, 100);
    tick();
    chk("tog_empty", valid, 0);
    d2p = 32'hA;
    tick();
    chk("tog_valid1", valid, 1);
    chk("tog_d2p1", evt_d2p, 32'hA);
    chk("tog_ts1", evt_ts, 102);
    tick();
    chk("tog_drained", valid, 0);
    chk("tog_drops", drops, 0);

    // Ten changes with ready low: eight kept, two dropped
    ready = 1'b0; d2p = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d2p = 32'(i + 1);
      tick();
    end
    chk("ovf_flag", ovf, 1);
    chk("ovf_drops", drops, 2);
    chk("ovf_valid", valid, 1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_d2p%0d", i), evt_d2p, 64'(i + 1));
      chk($sformatf("ovf_ts%0d", i), evt_ts, 64'(i));
      tick();
    end
    chk("ovf_drained", valid, 0);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_drops_after", drops, 2);

    // Full FIFO, change with simultaneous pop: nothing dropped
    ready = 1'b0; d2p = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d2p = 32'(i + 1);
      tick();
    end
    chk("full_drops0", drops, 0);
    d2p = 32'h64;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("full_pp_drops", drops, 0);
    chk("full_pp_ovf", ovf, 0);
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("full_d2p%0d", i), evt_d2p, 64'(i + 2));
      chk($sformatf("full_ts%0d", i), evt_ts, 64'(i + 1));
      tick();
    end
    chk("full_last_d2p", evt_d2p, 32'h64);
    chk("full_last_ts", evt_ts, 8);
    tick();
    chk("full_drained", valid, 0);

    // One-entry FIFO, push and pop together: new event becomes head
    ready = 1'b0; d2p = '0;
    do_reset();
    d2p = 32'h1;
    tick();
    chk("one_valid", valid, 1);
    ready = 1'b1;
    d2p = 32'h2;
    tick();
    chk("one_pp_valid", valid, 1);
    chk("one_pp_d2p", evt_d2p, 2);
    chk("one_pp_ts", evt_ts, 1);
    tick();
    chk("one_drained", valid, 0);

    // Asynchronous reset with five events queued
    ready = 1'b0; d2p = '0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d2p = 32'(i + 1);
      tick();
    end
    chk("mid_valid", valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_d2p", evt_d2p, 0);
    chk("mid_rst_ts", evt_ts, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_drops", drops, 0);
    d2p = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_no_stale", valid, 0);

    // 4-bit timestamp wrap: events at ts 15 and ts 0
    do_reset();
    repeat (15) tick();
    d2p4 = 32'h1;
    tick();
    d2p4 = 32'h2;
    tick();
    chk("wrap_valid", valid4, 1);
    chk("wrap_d2p0", evt_d2p4, 1);
    chk("wrap_ts0", evt_ts4, 15);
    ready4 = 1'b1;
    tick();
    chk("wrap_d2p1", evt_d2p4, 2);
    chk("wrap_ts1", evt_ts4, 0);
    tick();
    chk("wrap_drained", valid4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
